// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
// Contents:
//   state_e   - scanner FSM states (SCAN, DEBOUNCE, PRESSED)
//   KEY_*     - 4-bit key codes; digits 0-9 use their own value so the
//               code can be passed straight out as the digit
//   keyCode   - maps a (row, col) position on the keypad to its key code
//   keyIgnored - true for keys that must never be accepted (B, C, D)
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESSED
   } state_e;

   localparam logic [3:0] KEY_0    = 4'd0;
   localparam logic [3:0] KEY_1    = 4'd1;
   localparam logic [3:0] KEY_2    = 4'd2;
   localparam logic [3:0] KEY_3    = 4'd3;
   localparam logic [3:0] KEY_4    = 4'd4;
   localparam logic [3:0] KEY_5    = 4'd5;
   localparam logic [3:0] KEY_6    = 4'd6;
   localparam logic [3:0] KEY_7    = 4'd7;
   localparam logic [3:0] KEY_8    = 4'd8;
   localparam logic [3:0] KEY_9    = 4'd9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Sixteen keys fill the 4-bit code space, so "no key" shares the code of
   // D. That is safe because D (like B and C) is filtered out before the
   // FSM ever compares codes, so the FSM never sees D as a real key.
   localparam logic [3:0] KEY_NONE = KEY_D;

   // Physical layout, row-major:
   //   r1: 1 2 3 A   r2: 4 5 6 B   r3: 7 8 9 C   r4: * 0 # D
   function automatic logic [3:0] keyCode(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'd0:    code = KEY_1;
         4'd1:    code = KEY_2;
         4'd2:    code = KEY_3;
         4'd3:    code = KEY_A;
         4'd4:    code = KEY_4;
         4'd5:    code = KEY_5;
         4'd6:    code = KEY_6;
         4'd7:    code = KEY_B;
         4'd8:    code = KEY_7;
         4'd9:    code = KEY_8;
         4'd10:   code = KEY_9;
         4'd11:   code = KEY_C;
         4'd12:   code = KEY_STAR;
         4'd13:   code = KEY_0;
         4'd14:   code = KEY_HASH;
         default: code = KEY_D;
      endcase
      return code;
   endfunction

   function automatic logic keyIgnored(input logic [3:0] code);
      return (code == KEY_B) || (code == KEY_C) || (code == KEY_D);
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad and command bundle between the keypad matrix, the scanner and the
// downstream countdown logic.
//   row_1..row_4    keypad rows, active-low, asynchronous to clk
//   col_1..col_4    keypad columns, exactly one low at a time
//   keydown_*       one-cycle command pulses (start=A, confirm=#, clear=*,
//                   num=digit 0-9)
//   num             digit value, updated together with keydown_num
// master: the scanner. slave: the keypad/consumer side.
interface keypad_scanner_if;
   logic       row_1;
   logic       row_2;
   logic       row_3;
   logic       row_4;
   logic       col_1;
   logic       col_2;
   logic       col_3;
   logic       col_4;
   logic       keydown_start;
   logic       keydown_confirm;
   logic       keydown_clear;
   logic       keydown_num;
   logic [3:0] num;

   modport master (
      input  row_1, row_2, row_3, row_4,
      output col_1, col_2, col_3, col_4,
      output keydown_start, keydown_confirm, keydown_clear, keydown_num, num
   );

   modport slave (
      output row_1, row_2, row_3, row_4,
      input  col_1, col_2, col_3, col_4,
      input  keydown_start, keydown_confirm, keydown_clear, keydown_num, num
   );
endinterface

// File: rtl/scan_tick_gen.sv
// Prescaler producing a one-cycle scan tick every DIV clk cycles.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset (counter returns to 0)
//   tick_o  high for one cycle when the counter reaches DIV-1
module scan_tick_gen #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int          W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // The tick marks the last cycle of each period, so a column made active
   // at the start of a period has been driven for the whole period when
   // the rows are sampled.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with debounce and command decode.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   kp_if   keypad_scanner_if.master: rows in, columns out, command
//           pulses and held digit out
// One column is driven low per scan period; on each scan tick the
// synchronised rows are decoded to a key, debounced over DEBOUNCE_TICKS
// ticks, and an accepted key produces one registered one-cycle pulse.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   keypad_scanner_if.master        kp_if
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS);

   logic             scanTick;
   logic [3:0]       rowSync1_q, rowSync2_q;
   logic [3:0]       rowPressed;
   logic [3:0]       sampleKey;
   logic             keyPresent;
   logic             accept;
   logic [CNT_W-1:0] countInc, relInc;

   state_e           state_q, state_d;
   logic [1:0]       colIdx_q, colIdx_d;
   logic [3:0]       key_q, key_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] relCount_q, relCount_d;
   logic             startPulse_q, startPulse_d;
   logic             confirmPulse_q, confirmPulse_d;
   logic             clearPulse_q, clearPulse_d;
   logic             numPulse_q, numPulse_d;
   logic [3:0]       num_q, num_d;

   scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (scanTick)
   );

   // Rows are asynchronous; two flops before use. Reset to "all released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rowSync1_q <= 4'hF;
         rowSync2_q <= 4'hF;
      end else begin
         rowSync1_q <= {kp_if.row_4, kp_if.row_3, kp_if.row_2, kp_if.row_1};
         rowSync2_q <= rowSync1_q;
      end
   end

   assign rowPressed = ~rowSync2_q;

   // Decode the active column. Scanning rows from the highest down lets the
   // lowest-numbered pressed row overwrite, so it wins. An ignored key in
   // the winning row is treated as no key at all. keyPresent looks for the
   // latched key in any row so a release is judged on that key alone.
   always_comb begin
      sampleKey  = KEY_NONE;
      keyPresent = 1'b0;
      for (int r = 3; r >= 0; r--) begin
         if (rowPressed[r]) begin
            sampleKey = keyCode(2'(r), colIdx_q);
         end
      end
      if (keyIgnored(sampleKey)) begin
         sampleKey = KEY_NONE;
      end
      for (int r = 0; r < 4; r++) begin
         if (rowPressed[r] && (keyCode(2'(r), colIdx_q) == key_q)) begin
            keyPresent = 1'b1;
         end
      end
   end

   assign countInc = count_q + CNT_ONE;
   assign relInc   = relCount_q + CNT_ONE;

   // Next-state logic; everything moves only on a scan tick. The column
   // advances only when leaving for (or staying in) SCAN with no key, so a
   // candidate or held key keeps its column driven.
   always_comb begin
      state_d    = state_q;
      colIdx_d   = colIdx_q;
      key_d      = key_q;
      count_d    = count_q;
      relCount_d = relCount_q;
      accept     = 1'b0;
      if (scanTick) begin
         case (state_q)
            SCAN: begin
               if (sampleKey == KEY_NONE) begin
                  colIdx_d = colIdx_q + 2'd1;
               end else begin
                  key_d   = sampleKey;
                  count_d = CNT_ONE;
                  if (CNT_ONE == CNT_LAST) begin
                     accept     = 1'b1;
                     relCount_d = '0;
                     state_d    = PRESSED;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (sampleKey == KEY_NONE) begin
                  state_d  = SCAN;
                  colIdx_d = colIdx_q + 2'd1;
               end else if (sampleKey == key_q) begin
                  count_d = countInc;
                  if (countInc == CNT_LAST) begin
                     accept     = 1'b1;
                     relCount_d = '0;
                     state_d    = PRESSED;
                  end
               end else begin
                  key_d   = sampleKey;
                  count_d = CNT_ONE;
               end
            end
            PRESSED: begin
               if (keyPresent) begin
                  relCount_d = '0;
               end else begin
                  relCount_d = relInc;
                  if (relInc == CNT_LAST) begin
                     state_d  = SCAN;
                     colIdx_d = colIdx_q + 2'd1;
                  end
               end
            end
            default: begin
               state_d = SCAN;
            end
         endcase
      end
   end

   // Command pulses are decoded from the key being accepted this tick and
   // registered, so they appear the cycle after the tick for one cycle.
   always_comb begin
      startPulse_d   = accept && (key_d == KEY_A);
      confirmPulse_d = accept && (key_d == KEY_HASH);
      clearPulse_d   = accept && (key_d == KEY_STAR);
      numPulse_d     = accept && (key_d <= KEY_9);
      num_d          = numPulse_d ? key_d : num_q;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= SCAN;
         colIdx_q       <= 2'd0;
         key_q          <= KEY_NONE;
         count_q        <= '0;
         relCount_q     <= '0;
         startPulse_q   <= 1'b0;
         confirmPulse_q <= 1'b0;
         clearPulse_q   <= 1'b0;
         numPulse_q     <= 1'b0;
         num_q          <= 4'd0;
      end else begin
         state_q        <= state_d;
         colIdx_q       <= colIdx_d;
         key_q          <= key_d;
         count_q        <= count_d;
         relCount_q     <= relCount_d;
         startPulse_q   <= startPulse_d;
         confirmPulse_q <= confirmPulse_d;
         clearPulse_q   <= clearPulse_d;
         numPulse_q     <= numPulse_d;
         num_q          <= num_d;
      end
   end

   assign kp_if.col_1           = (colIdx_q != 2'd0);
   assign kp_if.col_2           = (colIdx_q != 2'd1);
   assign kp_if.col_3           = (colIdx_q != 2'd2);
   assign kp_if.col_4           = (colIdx_q != 2'd3);
   assign kp_if.keydown_start   = startPulse_q;
   assign kp_if.keydown_confirm = confirmPulse_q;
   assign kp_if.keydown_clear   = clearPulse_q;
   assign kp_if.keydown_num     = numPulse_q;
   assign kp_if.num             = num_q;

endmodule
